// File: rtl/pattern_ctrl.sv
// Pattern playback controller: key unlock, slot fetch/load/shift sequencing,
// and a button-driven program mode that writes one slot and plays it back.
module pattern_ctrl #(
    parameter int                 DATA_W    = 32,
    parameter int                 ADDR_W    = 2,
    parameter logic [DATA_W-1:0]  KEY       = DATA_W'(32'hDEADBEEF),
    parameter int                 TICK_DIV  = 1,
    parameter int                 SHIFT_LEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              prog_btn,
    input  logic              write_btn,
    input  logic              next_btn,
    input  logic [DATA_W-1:0] data,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [ADDR_W-1:0] addrb,
    output logic              load_en,
    output logic              shift_en,
    output logic              prog_mode
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SHIFT_LEN > 1) ? $clog2(SHIFT_LEN) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(SHIFT_LEN - 1);

    typedef enum logic [2:0] {LOCKED, FETCH, LOAD, RUN, PROG} state_t;

    state_t            state, state_next;
    logic [ADDR_W-1:0] rd_ptr, rd_next;
    logic [ADDR_W-1:0] wr_ptr, wr_next;
    logic [TW-1:0]     tick, tick_next;
    logic [SW-1:0]     shift_cnt, cnt_next;
    logic              prog_q, write_q, next_q;
    logic              prog_edge, write_edge, next_edge;

    // A held button produces a single event on its first cycle high
    assign prog_edge  = prog_btn  & ~prog_q;
    assign write_edge = write_btn & ~write_q;
    assign next_edge  = next_btn  & ~next_q;

    assign addra     = wr_ptr;
    assign addrb     = rd_ptr;
    assign prog_mode = (state == PROG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOCKED;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            tick      <= '0;
            shift_cnt <= '0;
            prog_q    <= 1'b0;
            write_q   <= 1'b0;
            next_q    <= 1'b0;
        end else begin
            state     <= state_next;
            rd_ptr    <= rd_next;
            wr_ptr    <= wr_next;
            tick      <= tick_next;
            shift_cnt <= cnt_next;
            prog_q    <= prog_btn;
            write_q   <= write_btn;
            next_q    <= next_btn;
        end
    end

    always_comb begin
        state_next = state;
        rd_next    = rd_ptr;
        wr_next    = wr_ptr;
        tick_next  = tick;
        cnt_next   = shift_cnt;
        wea        = 1'b0;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        case (state)
            LOCKED: begin
                if (data == KEY) state_next = FETCH;
            end
            FETCH: begin
                state_next = LOAD;
            end
            LOAD: begin
                load_en    = 1'b1;
                tick_next  = '0;
                cnt_next   = '0;
                state_next = RUN;
            end
            RUN: begin
                // Entering program mode pre-empts both the shift and a slot advance
                if (prog_edge) begin
                    state_next = PROG;
                end else if (tick == TICK_LAST) begin
                    tick_next = '0;
                    shift_en  = 1'b1;
                    if (shift_cnt == SHIFT_LAST) begin
                        cnt_next   = '0;
                        rd_next    = rd_ptr + ADDR_W'(1);
                        state_next = FETCH;
                    end else begin
                        cnt_next = shift_cnt + SW'(1);
                    end
                end else begin
                    tick_next = tick + TW'(1);
                end
            end
            PROG: begin
                if (write_edge) begin
                    wea        = 1'b1;
                    rd_next    = wr_ptr;
                    state_next = FETCH;
                end else if (prog_edge) begin
                    state_next = FETCH;
                end else if (next_edge) begin
                    wr_next = wr_ptr + ADDR_W'(1);
                end
            end
            default: state_next = LOCKED;
        endcase
    end

endmodule

// File: tb/tb_pattern_ctrl.sv
// Directed bench for pattern_ctrl: expected pulses are queued by the stimulus
// and popped by a monitor whenever the DUT emits wea/load_en/shift_en.
module tb_pattern_ctrl;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 2;
    localparam logic [31:0] KEY = 32'hDEADBEEF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              prog_btn = 1'b0;
    logic              write_btn = 1'b0;
    logic              next_btn = 1'b0;
    logic [DATA_W-1:0] data = '0;
    logic              wea, load_en, shift_en, prog_mode;
    logic [ADDR_W-1:0] addra, addrb;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        int         c;
        logic [2:0] p;   // {load_en, shift_en, wea}
        logic [1:0] a;
        logic [1:0] b;
    } exp_t;
    exp_t q[$];

    pattern_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KEY(KEY), .TICK_DIV(2), .SHIFT_LEN(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .prog_btn(prog_btn), .write_btn(write_btn),
        .next_btn(next_btn), .data(data), .wea(wea), .addra(addra), .addrb(addrb),
        .load_en(load_en), .shift_en(shift_en), .prog_mode(prog_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every pulse seen must match the head of the queue
    always @(negedge clk) begin
        if (rst_n && (load_en || shift_en || wea)) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse cyc=%0d got {load,shift,wea}=%b addra=%0d addrb=%0d, none expected",
                         cyc, {load_en, shift_en, wea}, addra, addrb);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.c != cyc || e.p != {load_en, shift_en, wea} || e.a != addra || e.b != addrb) begin
                    n_fail++;
                    $display("FAIL pulse got cyc=%0d p=%b a=%0d b=%0d, expected cyc=%0d p=%b a=%0d b=%0d",
                             cyc, {load_en, shift_en, wea}, addra, addrb, e.c, e.p, e.a, e.b);
                end
            end
        end
    end

    task automatic push(input int c, input logic [2:0] p, input logic [1:0] a, input logic [1:0] b);
        exp_t e;
        e.c = c; e.p = p; e.a = a; e.b = b;
        q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    task automatic check_idle(input string name);
        check({name, "_wea"}, 32'(wea), 0);
        check({name, "_load"}, 32'(load_en), 0);
        check({name, "_shift"}, 32'(shift_en), 0);
        check({name, "_prog"}, 32'(prog_mode), 0);
        check({name, "_addra"}, 32'(addra), 0);
        check({name, "_addrb"}, 32'(addrb), 0);
    endtask

    initial begin
        #2;
        check_idle("reset");
        wait_cyc(3);
        rst_n = 1'b1;

        // Locked with a wrong key, then unlock at window 14
        wait_cyc(13);
        check("locked_prog", 32'(prog_mode), 0);
        wait_cyc(14);
        data = KEY;
        for (int s = 0; s < 4; s++) begin
            push(16 + 10 * s, 3'b100, 2'd0, 2'(s));
            for (int j = 0; j < 4; j++) push(18 + 10 * s + 2 * j, 3'b010, 2'd0, 2'(s));
        end
        push(56, 3'b100, 2'd0, 2'd0);
        for (int j = 0; j < 3; j++) push(58 + 2 * j, 3'b010, 2'd0, 2'd0);
        wait_cyc(15);
        data = '0;

        // Prog press on the cycle of the 4th shift: no shift, no advance; held 20 cycles
        wait_cyc(64);
        prog_btn = 1'b1;
        wait_cyc(66);
        check("prio_prog_mode", 32'(prog_mode), 1);
        check("prio_addrb", 32'(addrb), 0);
        wait_cyc(84);
        check("held_prog_mode", 32'(prog_mode), 1);
        prog_btn = 1'b0;
        wait_cyc(85); next_btn = 1'b1;
        wait_cyc(86); next_btn = 1'b0;
        wait_cyc(87); next_btn = 1'b1;
        wait_cyc(88); next_btn = 1'b0;
        wait_cyc(89);
        check("next2_addra", 32'(addra), 2);

        // Write slot 2, read back and run, then re-enter program mode
        wait_cyc(90);
        write_btn = 1'b1;
        push(90, 3'b001, 2'd2, 2'd0);
        push(92, 3'b100, 2'd2, 2'd2);
        push(94, 3'b010, 2'd2, 2'd2);
        wait_cyc(91);
        write_btn = 1'b0;
        check("write_addrb", 32'(addrb), 2);
        wait_cyc(95); prog_btn = 1'b1;
        wait_cyc(96); prog_btn = 1'b0;
        wait_cyc(97);
        check("reprog_mode", 32'(prog_mode), 1);

        // Walk wr_ptr 2 -> 3 -> 0 -> 1 (wrap), then write+next together
        for (int k = 0; k < 3; k++) begin
            wait_cyc(97 + 2 * k); next_btn = 1'b1;
            wait_cyc(98 + 2 * k); next_btn = 1'b0;
        end
        wait_cyc(103);
        check("wrap_addra", 32'(addra), 1);
        wait_cyc(104);
        write_btn = 1'b1;
        next_btn  = 1'b1;
        push(104, 3'b001, 2'd1, 2'd2);
        push(106, 3'b100, 2'd1, 2'd1);
        push(108, 3'b010, 2'd1, 2'd1);
        wait_cyc(105);
        write_btn = 1'b0;
        next_btn  = 1'b0;
        check("wn_addra", 32'(addra), 1);
        check("wn_addrb", 32'(addrb), 1);
        wait_cyc(109); prog_btn = 1'b1;
        wait_cyc(110); prog_btn = 1'b0;
        wait_cyc(111);
        check("prog3_mode", 32'(prog_mode), 1);

        // Abort from program mode: reload without a write
        wait_cyc(112);
        prog_btn = 1'b1;
        push(114, 3'b100, 2'd1, 2'd1);
        push(116, 3'b010, 2'd1, 2'd1);
        wait_cyc(113);
        prog_btn = 1'b0;
        check("abort_mode", 32'(prog_mode), 0);
        wait_cyc(117); prog_btn = 1'b1;
        wait_cyc(118); prog_btn = 1'b0;
        wait_cyc(119); next_btn = 1'b1;
        wait_cyc(120); next_btn = 1'b0;
        wait_cyc(121); next_btn = 1'b1;
        wait_cyc(122); next_btn = 1'b0;
        wait_cyc(123);
        check("pre_rst_addra", 32'(addra), 3);
        check("pre_rst_mode", 32'(prog_mode), 1);

        // Asynchronous reset between clock edges
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        wait_cyc(126);
        rst_n = 1'b1;
        wait_cyc(130);
        check("relock_mode", 32'(prog_mode), 0);
        check("relock_addrb", 32'(addrb), 0);
        wait_cyc(131);
        data = KEY;
        push(133, 3'b100, 2'd0, 2'd0);
        push(135, 3'b010, 2'd0, 2'd0);
        wait_cyc(132);
        data = '0;
        wait_cyc(136);

        check("queue_drained", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_ctrl.md
PATTERN_CTRL -- requirements
Module: pattern_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, width of the unlock key compare bus.
REQ-002 Parameter ADDR_W, default 2, pattern-slot address width; slot count = 2**ADDR_W.
REQ-003 Parameter KEY, default 32'hDEADBEEF (DATA_W bits), unlock value.
REQ-004 Parameter TICK_DIV, default 1, clock cycles per shift pulse (>=1).
REQ-005 Parameter SHIFT_LEN, default 32, shift pulses per pattern before advancing to the next slot (>=1).
REQ-006 clk  in  1  single clock, all logic on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 prog_btn  in  1  enter/abort program mode, synchronous level.
REQ-009 write_btn  in  1  commit write in program mode, synchronous level.
REQ-010 next_btn  in  1  advance write slot in program mode, synchronous level.
REQ-011 data  in  DATA_W  unlock key input.
REQ-012 wea  out  1  pattern RAM port-A write enable.
REQ-013 addra  out  ADDR_W  port-A write address (= wr_ptr at all times).
REQ-014 addrb  out  ADDR_W  port-B read address (= rd_ptr at all times); RAM read latency is 1 cycle.
REQ-015 load_en  out  1  load shifter from port-B data.
REQ-016 shift_en  out  1  shift pulse.
REQ-017 prog_mode  out  1  high while in PROG.

Function
REQ-018 Each button SHALL be rising-edge detected against a one-cycle-delayed copy (edge = btn & ~btn_q); a held button SHALL yield exactly one event.
REQ-019 States: LOCKED, FETCH, LOAD, RUN, PROG; registered state, outputs decoded from state, pointers and edge events.
REQ-020 LOCKED: all pulse outputs 0; data == KEY -> FETCH next cycle; any other value stays.
REQ-021 FETCH: one wait cycle for RAM read of addrb, no pulse outputs; unconditionally -> LOAD.
REQ-022 LOAD: load_en = 1 for exactly this cycle; tick and shift counters cleared to 0; -> RUN.
REQ-023 RUN: tick counter counts 0..TICK_DIV-1 and wraps; shift_en = 1 in cycles where tick == TICK_DIV-1.
REQ-024 RUN: on the cycle of the SHIFT_LEN-th shift_en, rd_ptr increments modulo 2**ADDR_W and state -> FETCH.
REQ-025 RUN: prog_btn edge -> PROG, shift_en forced 0 that cycle; prog_btn edge has priority over slot advance in the same cycle (rd_ptr unchanged).
REQ-026 PROG: shift_en = 0, load_en = 0; next_btn edge increments wr_ptr modulo 2**ADDR_W.
REQ-027 PROG: write_btn edge -> wea = 1 for that single cycle at addra = wr_ptr; rd_ptr <= wr_ptr; -> FETCH (new pattern read back and loaded).
REQ-028 PROG: write_btn and next_btn edges in same cycle -> write at current wr_ptr, wr_ptr unchanged.
REQ-029 PROG: prog_btn edge with no write_btn edge -> abort to FETCH, no wea, rd_ptr unchanged; write_btn edge wins if both.
REQ-030 Counter widths SHALL be $clog2 of their range (minimum 1 bit); no overflow beyond terminal counts.

Reset
REQ-031 rst_n low SHALL immediately force state LOCKED, rd_ptr = wr_ptr = 0, tick = shift count = 0, button delay regs = 0, and wea, load_en, shift_en, prog_mode = 0, addra = addrb = 0, irrespective of clk.
REQ-032 After deassertion, operation resumes from LOCKED on the next rising edge; re-unlock required.

Verification (ADDR_W=2, TICK_DIV=2, SHIFT_LEN=4 unless noted)
REQ-033 Unlock: data=0 for 10 cycles -> all pulse outputs 0; data=32'hDEADBEEF at edge k -> FETCH k+1, load_en high only in cycle k+2, shift_en high in RUN cycles 2,4,6,8.
REQ-034 Advance/wrap: after 4th shift_en addrb 0->1, load_en 2 cycles later; after slot 3 addrb wraps to 0.
REQ-035 Program: prog_btn pulse -> prog_mode=1, shift_en=0; next_btn twice -> addra=2; write_btn -> wea=1 one cycle with addra=2, then addrb=2, load_en 2 cycles after wea.
REQ-036 Held buttons: prog_btn high 20 cycles -> single PROG entry; write+next same cycle at wr_ptr=1 -> wea at addra=1, addra stays 1; prog_btn in PROG -> FETCH, no wea.
REQ-037 Priority: prog_btn edge on cycle of 4th shift_en -> PROG, shift_en=0, addrb unchanged.
REQ-038 Reset mid-PROG (wr_ptr=3): rst_n low asynchronously -> outputs 0 and addra=addrb=0 before next clk edge; after release stays LOCKED until data=KEY.
